// File: rtl/diffusion_layer_seq_pkg.sv
// Shared ASCON types, p_L rotation constants and the 64-bit right-rotate helper.
// Also holds the FSM state encoding for the sequential diffusion layer.
package ascon_pack;

  typedef logic [319:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } dl_state_e;

  // Indexed by word number: x0 uses ROT_A[0]/ROT_B[0], and so on.
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr64(input logic [63:0] word, input int unsigned amt);
    return (word >> amt) | (word << (64 - amt));
  endfunction

endpackage

// File: rtl/diffusion_layer_seq_if.sv
// Valid/ready stream into and out of the diffusion layer, plus its busy flag.
// The block itself uses the slave modport; the feeding logic uses master.
interface diffusion_layer_seq_if;
  import ascon_pack::*;

  logic      in_valid_i;
  logic      in_ready_o;
  type_state state_i;
  logic      out_valid_o;
  logic      out_ready_i;
  type_state state_o;
  logic      busy_o;

  modport slave (
    input  in_valid_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, busy_o
  );

  modport master (
    output in_valid_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, busy_o
  );

endinterface

// File: rtl/diffusion_layer_seq_lane.sv
// One p_L word lane: x ^ rotr(x, ROT_A[idx]) ^ rotr(x, ROT_B[idx]).
// Purely combinational; idx selects which word's rotation pair applies.
module diffusion_lane
  import ascon_pack::*;
(
  input  logic [63:0] i_word,
  input  logic [2:0]  i_idx,
  output logic [63:0] o_word
);

  int unsigned w_rot_a;
  int unsigned w_rot_b;

  // NOTE: defaults first so every path assigns both amounts; no latch is inferred.
  always_comb begin
    w_rot_a = 0;
    w_rot_b = 0;
    for (int k = 0; k < 5; k++) begin
      if (i_idx == 3'(k)) begin
        w_rot_a = ROT_A[k];
        w_rot_b = ROT_B[k];
      end
    end
  end

  assign o_word = i_word ^ rotr64(i_word, w_rot_a) ^ rotr64(i_word, w_rot_b);

endmodule

// File: rtl/diffusion_layer_seq.sv
// Sequential, handshaked ASCON linear diffusion layer over the 320-bit state.
// LANES words are diffused in place per cycle; the result is held until consumed.
module diffusion_layer_seq
  import ascon_pack::*;
#(
  parameter int LANES = 1
) (
  input logic                  clock_i,
  input logic                  resetb_i,
  diffusion_layer_seq_if.slave bus
);

  localparam int          NSTEP    = 5 / LANES;
  localparam logic [2:0]  LAST_CNT = 3'((NSTEP - 1) * LANES);

  if (LANES != 1 && LANES != 5) begin : g_bad_lanes
    $error("diffusion_layer_seq: LANES must be 1 or 5");
  end

  dl_state_e   r_fsm;
  type_state   r_work;
  logic [2:0]  r_cnt;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_in_ready;
  logic [63:0] w_diff [LANES];
  logic [8:0]  w_base [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [2:0] w_idx;
    assign w_idx     = r_cnt + 3'(g);
    assign w_base[g] = {w_idx, 6'b0};

    diffusion_lane u_lane (
      .i_word (r_work[w_base[g] +: 64]),
      .i_idx  (w_idx),
      .o_word (w_diff[g])
    );
  end

  // A finished result can be handed off in the same cycle a new state is taken.
  assign w_in_ready      = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & bus.out_ready_i);
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.state_o     = r_work;
  assign bus.busy_o      = r_busy;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm       <= ST_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            r_work <= bus.state_i;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_fsm  <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int g = 0; g < LANES; g++) begin
            r_work[w_base[g] +: 64] <= w_diff[g];
          end
          if (r_cnt == LAST_CNT) begin
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 3'(LANES);
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            if (bus.in_valid_i) begin
              r_work <= bus.state_i;
              r_cnt  <= '0;
              r_busy <= 1'b1;
              r_fsm  <= ST_RUN;
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

endmodule
